// File: rtl/sha512_pad_if.sv
// Stream bundle for the SHA-512 padder: 64-bit message beats in, 1024-bit padded chunks out.
// The master modport is the producer/consumer side; the slave modport is the padder itself.
interface sha512_pad_if;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          out_valid;
  logic          out_ready;
  logic [1023:0] out_chunk;
  logic          out_first;
  logic          out_last;

  modport master (
    output in_valid, in_data, in_last, in_bytes, out_ready,
    input  in_ready, out_valid, out_chunk, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, out_ready,
    output in_ready, out_valid, out_chunk, out_first, out_last
  );
endinterface

// File: rtl/sha512_pad.sv
// SHA-512 message padder: packs big-endian 64-bit beats into 1024-bit chunks, appends the
// 0x80 marker, zero fill and 128-bit bit-length, spilling into an extra chunk when needed.
module sha512_pad (
  input  logic              clk,
  input  logic              reset,
  sha512_pad_if.slave       bus
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         widx_q, widx_d;
  logic [63:0]        cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               mark_q, mark_d;
  logic               first_q, first_d;
  logic               ofirst_q, ofirst_d;
  logic               olast_q, olast_d;
  logic [15:0][63:0]  chunk_q, chunk_d;

  logic [3:0]         nb_s;
  logic [4:0]         mark_pos_s;
  logic               fits_s;
  logic [63:0]        total_s;

  // Keep the first nb bytes, put 0x80 right after them, zero the rest.
  function automatic logic [63:0] pad_word(input logic [63:0] d, input logic [3:0] nb);
    logic [63:0] w;
    w = 64'd0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < nb) begin
        w[63-8*b -: 8] = d[63-8*b -: 8];
      end else if (4'(b) == nb) begin
        w[63-8*b -: 8] = 8'h80;
      end else begin
        w[63-8*b -: 8] = 8'h00;
      end
    end
    return w;
  endfunction

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_chunk = chunk_q;
  assign bus.out_first = ofirst_q;
  assign bus.out_last  = olast_q;

  // Next-state and datapath update for the fill/emit controller.
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    mark_d     = mark_q;
    first_d    = first_q;
    ofirst_d   = ofirst_q;
    olast_d    = olast_q;
    chunk_d    = chunk_q;
    nb_s       = (bus.in_bytes > 4'd8) ? 4'd8 : bus.in_bytes;
    mark_pos_s = {1'b0, widx_q} + {4'd0, (nb_s == 4'd8)};
    fits_s     = (mark_pos_s <= 5'd13);
    total_s    = cnt_q + {60'd0, nb_s};

    case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          if (!bus.in_last) begin
            chunk_d[4'd15 - widx_q] = bus.in_data;
            widx_d = widx_q + 4'd1;
            cnt_d  = cnt_q + 64'd8;
            if (widx_q == 4'd15) begin
              state_d  = EMIT;
              olast_d  = 1'b0;
              ofirst_d = first_q;
              first_d  = 1'b0;
            end else begin
              state_d = FILL;
            end
          end else begin
            for (int j = 0; j < 16; j++) begin
              if (4'(j) > widx_q) begin
                chunk_d[4'(15 - j)] = 64'd0;
              end else begin
                chunk_d[4'(15 - j)] = chunk_q[4'(15 - j)];
              end
            end
            chunk_d[4'd15 - widx_q] = pad_word(bus.in_data, nb_s);
            // A full final word pushes the marker to the start of the next word.
            if ((nb_s == 4'd8) && (widx_q != 4'd15)) begin
              chunk_d[4'd14 - widx_q] = 64'h8000_0000_0000_0000;
            end else begin
              chunk_d[4'd15 - widx_q] = pad_word(bus.in_data, nb_s);
            end
            cnt_d    = total_s;
            widx_d   = 4'd0;
            state_d  = EMIT;
            ofirst_d = first_q;
            first_d  = 1'b0;
            if (fits_s) begin
              chunk_d[1] = {61'd0, total_s[63:61]};
              chunk_d[0] = {total_s[60:0], 3'd0};
              olast_d    = 1'b1;
              pend_d     = 1'b0;
            end else begin
              olast_d = 1'b0;
              pend_d  = 1'b1;
              mark_d  = !((widx_q == 4'd15) && (nb_s == 4'd8));
            end
          end
        end else begin
          state_d = FILL;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (olast_q) begin
            state_d = FILL;
            cnt_d   = 64'd0;
            widx_d  = 4'd0;
            first_d = 1'b1;
          end else if (pend_q) begin
            chunk_d     = '0;
            chunk_d[15] = mark_q ? 64'd0 : 64'h8000_0000_0000_0000;
            chunk_d[1]  = {61'd0, cnt_q[63:61]};
            chunk_d[0]  = {cnt_q[60:0], 3'd0};
            pend_d      = 1'b0;
            olast_d     = 1'b1;
            ofirst_d    = 1'b0;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= FILL;
      widx_q   <= 4'd0;
      cnt_q    <= 64'd0;
      pend_q   <= 1'b0;
      mark_q   <= 1'b0;
      first_q  <= 1'b1;
      ofirst_q <= 1'b0;
      olast_q  <= 1'b0;
      chunk_q  <= '0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      mark_q   <= mark_d;
      first_q  <= first_d;
      ofirst_q <= ofirst_d;
      olast_q  <= olast_d;
      chunk_q  <= chunk_d;
    end
  end

endmodule

// File: tb/tb_sha512_pad.sv
// Directed bench for sha512_pad: known-answer padded chunks, stall hold and mid-message reset.
module tb_sha512_pad;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [63:0] ew [16];

  sha512_pad_if bus ();

  sha512_pad dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dat(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h0F0F_1000 + 32'(i)};
  endfunction

  task automatic clear_exp();
    for (int j = 0; j < 16; j++) ew[j] = 64'd0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic l, input logic [3:0] nb);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_bytes = nb;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!ok) check_vec("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic recv_check(input string tag, input logic ef, input logic el);
    bit ok;
    int n;
    logic [1023:0] got;
    logic gf, gl;
    ok  = 1'b0;
    n   = 0;
    got = '0;
    gf  = 1'b0;
    gl  = 1'b0;
    bus.out_ready = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.out_valid;
      if (ok) begin
        got = bus.out_chunk;
        gf  = bus.out_first;
        gl  = bus.out_last;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.out_ready = 1'b0;
    if (!ok) begin
      check_vec({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      for (int j = 0; j < 16; j++)
        check_vec($sformatf("%s_w%0d", tag, j), got[64*(15-j) +: 64], ew[j]);
      check_vec({tag, "_first"}, {63'd0, gf}, {63'd0, ef});
      check_vec({tag, "_last"}, {63'd0, gl}, {63'd0, el});
      if (el) check_vec({tag, "_inrdy"}, {63'd0, bus.in_ready}, 64'd1);
    end
  endtask

  task automatic check_lat(input string tag);
    check_vec({tag, "_lat"}, {63'd0, bus.out_valid}, 64'd1);
  endtask

  task automatic exp_abc();
    clear_exp();
    ew[0]  = 64'h6162_6380_0000_0000;
    ew[15] = 64'h0000_0000_0000_0018;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'd0;
    bus.in_last   = 1'b0;
    bus.in_bytes  = 4'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check_vec("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check_vec("rst_out_first", {63'd0, bus.out_first}, 64'd0);
    check_vec("rst_out_last", {63'd0, bus.out_last}, 64'd0);
    for (int j = 0; j < 16; j++)
      check_vec($sformatf("rst_w%0d", j), bus.out_chunk[64*(15-j) +: 64], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Empty message
    send_beat(64'd0, 1'b1, 4'd0);
    check_lat("empty");
    clear_exp();
    ew[0] = 64'h8000_0000_0000_0000;
    recv_check("empty", 1'b1, 1'b1);

    // "abc"
    send_beat(64'h6162_6300_0000_0000, 1'b1, 4'd3);
    check_lat("abc");
    exp_abc();
    recv_check("abc", 1'b1, 1'b1);

    // 21 bytes: two full beats plus 5 bytes
    send_beat(64'h0123_4567_89AB_CDEF, 1'b0, 4'd0);
    send_beat(64'hFEDC_BA98_7654_3210, 1'b0, 4'd0);
    send_beat(64'h1122_3344_5566_7788, 1'b1, 4'd5);
    check_lat("p21");
    clear_exp();
    ew[0]  = 64'h0123_4567_89AB_CDEF;
    ew[1]  = 64'hFEDC_BA98_7654_3210;
    ew[2]  = 64'h1122_3344_5580_0000;
    ew[15] = 64'h0000_0000_0000_00A8;
    recv_check("p21", 1'b1, 1'b1);

    // in_bytes above 8 behaves as 8
    send_beat(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 4'd12);
    check_lat("clamp");
    clear_exp();
    ew[0]  = 64'hDEAD_BEEF_CAFE_F00D;
    ew[1]  = 64'h8000_0000_0000_0000;
    ew[15] = 64'h0000_0000_0000_0040;
    recv_check("clamp", 1'b1, 1'b1);

    // 112 bytes: marker lands in word 14, length spills to a second chunk
    for (int i = 0; i < 14; i++) send_beat(dat(i), (i == 13), 4'd8);
    check_lat("m112");
    clear_exp();
    for (int i = 0; i < 14; i++) ew[i] = dat(i);
    ew[14] = 64'h8000_0000_0000_0000;
    recv_check("m112a", 1'b1, 1'b0);
    clear_exp();
    ew[15] = 64'h0000_0000_0000_0380;
    recv_check("m112b", 1'b0, 1'b1);

    // 128 bytes: marker goes into the pad chunk
    for (int i = 0; i < 16; i++) send_beat(dat(i), (i == 15), 4'd8);
    check_lat("m128");
    clear_exp();
    for (int i = 0; i < 16; i++) ew[i] = dat(i);
    recv_check("m128a", 1'b1, 1'b0);
    clear_exp();
    ew[0]  = 64'h8000_0000_0000_0000;
    ew[15] = 64'h0000_0000_0000_0400;
    recv_check("m128b", 1'b0, 1'b1);

    // Consumer stall holds the chunk
    send_beat(64'h6162_0000_0000_0000, 1'b1, 4'd2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_vec("stall_valid", {63'd0, bus.out_valid}, 64'd1);
      check_vec("stall_inrdy", {63'd0, bus.in_ready}, 64'd0);
      check_vec("stall_w0", bus.out_chunk[1023:960], 64'h6162_8000_0000_0000);
      check_vec("stall_w15", bus.out_chunk[63:0], 64'h0000_0000_0000_0010);
      check_vec("stall_first", {63'd0, bus.out_first}, 64'd1);
      check_vec("stall_last", {63'd0, bus.out_last}, 64'd1);
    end
    @(posedge clk);
    #1;
    clear_exp();
    ew[0]  = 64'h6162_8000_0000_0000;
    ew[15] = 64'h0000_0000_0000_0010;
    recv_check("stall", 1'b1, 1'b1);

    // Reset after five beats discards them
    for (int i = 0; i < 5; i++) send_beat(dat(i), 1'b0, 4'd8);
    rst_n = 1'b0;
    #2;
    check_vec("midrst_inrdy", {63'd0, bus.in_ready}, 64'd1);
    check_vec("midrst_w0", bus.out_chunk[1023:960], 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(64'h6162_6300_0000_0000, 1'b1, 4'd3);
    check_lat("rstabc");
    exp_abc();
    recv_check("rstabc", 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not complete");
  end

endmodule
